// File: rtl/uart_tx_fifo_serializer_if.sv
// Write-side handshake between the register block and the UART transmit stage.
// Handshake: a byte transfers on a rising clock edge exactly when i_wr_valid and
// o_wr_ready are both high; i_wr_data must be stable while i_wr_valid is high,
// o_wr_ready does not depend on i_wr_valid, and a valid byte offered while
// o_wr_ready is low is dropped (the transmitter flags it as an overflow).
interface uart_tx_fifo_serializer_if;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic [7:0] i_wr_data;

  modport master (output i_wr_valid, output i_wr_data, input o_wr_ready);
  modport slave  (input i_wr_valid, input i_wr_data, output o_wr_ready);
endinterface

// File: rtl/uart_tx_fifo_serializer.sv
// UART transmit stage: byte FIFO followed by an 8N1, LSB-first serializer.
// Line outputs are registered from the FSM state, so the line lags the state by
// one clock uniformly; frame length and inter-frame gaps are unaffected.
module uart_tx_fifo_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  uart_tx_fifo_serializer_if.slave  wr,
  input  logic                      i_clr_overflow,
  output logic                      uart_txd,
  output logic                      o_tx_active,
  output logic                      o_tx_done,
  output logic [2:0]                o_SM_Main,
  output logic [FIFO_AW:0]          o_fifo_count,
  output logic                      o_fifo_full,
  output logic                      o_fifo_empty,
  output logic                      o_overflow
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  logic [1:0]         rst_pipe;
  logic               rst_n;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               overflow;
  state_t             state, state_next;
  logic [BAUD_W-1:0]  baud_cnt, baud_next;
  logic [2:0]         bit_idx, bit_next;
  logic [7:0]         shift, shift_next;
  logic               baud_done;

  // Reset asserts immediately but releases two clocks later, synchronous to the clock.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) rst_pipe <= 2'b00;
    else                  rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  assign full          = (count == COUNT_FULL);
  assign empty         = (count == '0);
  assign wr.o_wr_ready = !full;
  assign push          = wr.i_wr_valid && !full;
  assign baud_done     = (baud_cnt == BAUD_LAST);

  // FIFO storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge s00_axi_aclk) begin
    if (push) mem[wr_ptr] <= wr.i_wr_data;
  end

  // Pointers wrap naturally at 2**FIFO_AW; count tracks push/pop, unchanged when both occur.
  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a new overflow in the same cycle as a clear keeps it set.
  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n)                          overflow <= 1'b0;
    else if (wr.i_wr_valid && full)      overflow <= 1'b1;
    else if (i_clr_overflow)             overflow <= 1'b0;
  end

  // FSM state, baud counter, bit index and shift register.
  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
    end
  end

  // Next-state logic: pop in IDLE, then hold each line level for CLKS_PER_BIT clocks.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next  = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 1'b1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next  = '0;
          state_next = CLEANUP;
        end else begin
          baud_next  = baud_cnt + 1'b1;
        end
      end
      CLEANUP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered line outputs derived from the current state.
  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      uart_txd    <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      uart_txd    <= (state == START) ? 1'b0 :
                     (state == DATA)  ? shift[bit_idx] : 1'b1;
      o_tx_active <= (state == START) || (state == DATA) || (state == STOP);
      o_tx_done   <= (state == CLEANUP);
    end
  end

  assign o_SM_Main    = state;
  assign o_fifo_count = count;
  assign o_fifo_full  = full;
  assign o_fifo_empty = empty;
  assign o_overflow   = overflow;

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Bench for uart_tx_fifo_serializer: a line decoder recovers frames from
// uart_txd and checks them against an expected-byte queue; tasks check FIFO
// status, overflow, frame timing and reset behaviour.
module tb_uart_tx_fifo_serializer;
  localparam int CPB      = 4;
  localparam int AW       = 4;
  localparam int FRAME    = 10 * CPB;
  localparam int PERIOD_F = FRAME + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          txd, tx_active, tx_done, full, empty, ovf;
  logic [2:0]    sm;
  logic [AW:0]   count;

  int            checks = 0;
  int            fails = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            fill_e0 = 0;
  int            fill_d0 = 0;
  bit            mon_en = 1'b1;
  logic [7:0]    exp_q[$];
  int            start_q[$];

  uart_tx_fifo_serializer_if wr_if();

  uart_tx_fifo_serializer #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .wr              (wr_if.slave),
    .i_clr_overflow  (clr),
    .uart_txd        (txd),
    .o_tx_active     (tx_active),
    .o_tx_done       (tx_done),
    .o_SM_Main       (sm),
    .o_fifo_count    (count),
    .o_fifo_full     (full),
    .o_fifo_empty    (empty),
    .o_overflow      (ovf)
  );

  // clock / cycle index (cyc = number of the most recent rising edge)
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required the run to complete");
    $fatal(1, "watchdog");
  end

  // line decoder + scoreboard: samples txd once per clock, frames are 10 bits of CPB samples
  initial begin : line_monitor
    logic [FRAME-1:0] smp;
    logic [9:0]       bits;
    logic [7:0]       b, e;
    int               n, st;
    bit               busy, post, act_ok, ok;
    busy = 0; post = 0; n = 0; st = 0; act_ok = 0;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
      if (!mon_en) begin
        busy = 0;
        post = 0;
      end else if (busy) begin
        smp[n] = txd;
        if (tx_active !== 1'b1) act_ok = 0;
        n++;
        if (n == FRAME) begin
          busy = 0;
          post = 1;
          ok = act_ok;
          for (int k = 0; k < 10; k++) begin
            bits[k] = smp[k*CPB];
            for (int j = 1; j < CPB; j++) if (smp[k*CPB+j] !== bits[k]) ok = 0;
          end
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 0;
          b = bits[8:1];
          checks++;
          if (!ok) begin
            fails++;
            $display("FAIL frame_shape: samples(bit0 rightmost)=%b active_held=%0d, required start 0, 8 steady bits, stop 1",
                     smp, act_ok);
          end
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_frame: got byte 0x%02h at cycle %0d, required no frame", b, st);
          end else begin
            e = exp_q.pop_front();
            if (b !== e) begin
              fails++;
              $display("FAIL frame_byte: got 0x%02h, required 0x%02h", b, e);
            end
          end
          start_q.push_back(st);
        end
      end else if (post) begin
        post = 0;
        checks++;
        if (tx_done !== 1'b1 || tx_active !== 1'b0 || txd !== 1'b1) begin
          fails++;
          $display("FAIL done_pulse: done=%b active=%b txd=%b after stop bit, required 1 0 1",
                   tx_done, tx_active, txd);
        end
      end else if (txd === 1'b0) begin
        busy = 1;
        smp[0] = txd;
        n = 1;
        act_ok = (tx_active === 1'b1);
        st = cyc;
      end
    end
  end

  // driver: offer one byte for exactly one rising edge; e = index of that edge
  task automatic drive_push(input logic [7:0] d, output int e);
    @(negedge clk);
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_data  = d;
    @(posedge clk);
    #1;
    e = cyc;
    wr_if.i_wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, tx_active, tx_done, sm, count, empty, full, wr_if.o_wr_ready, ovf} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_held: txd=%b act=%b done=%b sm=%0d cnt=%0d empty=%b full=%b ready=%b ovf=%b, required 1 0 0 0 0 1 0 1 0",
               txd, tx_active, tx_done, sm, count, empty, full, wr_if.o_wr_ready, ovf);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({txd, tx_active, sm, count, empty, wr_if.o_wr_ready, ovf} !==
        {1'b1, 1'b0, 3'd0, 5'd0, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_release: txd=%b act=%b sm=%0d cnt=%0d empty=%b ready=%b ovf=%b, required 1 0 0 0 1 1 0",
               txd, tx_active, sm, count, empty, wr_if.o_wr_ready, ovf);
    end
  endtask

  task automatic test_single_byte();
    int e, d0;
    d0 = done_cnt;
    start_q.delete();
    exp_q.push_back(8'hA5);
    drive_push(8'hA5, e);
    checks++;
    if (count !== 5'd1 || empty !== 1'b0) begin
      fails++;
      $display("FAIL single_count_push: cnt=%0d empty=%b, required 1 0", count, empty);
    end
    @(posedge clk);
    #1;
    checks++;
    if (count !== 5'd0 || sm !== 3'd1) begin
      fails++;
      $display("FAIL single_pop: cnt=%0d sm=%0d, required 0 1", count, sm);
    end
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_drain: %0d bytes not seen, required 0", exp_q.size());
    end
    checks++;
    if (start_q.size() != 1 || start_q[0] != e + 2) begin
      fails++;
      $display("FAIL single_start: frames=%0d first start=%0d, required 1 frame at %0d",
               start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, e + 2);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL single_done_count: %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3] = '{8'h00, 8'hFF, 8'h3C};
    int e, e0, d0, peak;
    d0 = done_cnt;
    peak = 0;
    start_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      drive_push(pat[i], e);
      if (i == 0) e0 = e;
      if (int'(count) > peak) peak = int'(count);
    end
    checks++;
    if (peak < 2 || peak > 3) begin
      fails++;
      $display("FAIL b2b_peak: peak count %0d, required 2..3", peak);
    end
    wait_drain(400);
    checks++;
    if (exp_q.size() != 0 || start_q.size() != 3) begin
      fails++;
      $display("FAIL b2b_frames: missing=%0d frames=%0d, required 0 3", exp_q.size(), start_q.size());
    end
    for (int k = 0; k < 3 && k < start_q.size(); k++) begin
      checks++;
      if (start_q[k] != e0 + 2 + k * PERIOD_F) begin
        fails++;
        $display("FAIL b2b_start%0d: start at %0d, required %0d", k, start_q[k], e0 + 2 + k * PERIOD_F);
      end
    end
    checks++;
    if (done_cnt - d0 != 3) begin
      fails++;
      $display("FAIL b2b_done_count: %0d pulses, required 3", done_cnt - d0);
    end
  endtask

  task automatic test_random_bursts();
    int e, n;
    logic [7:0] d;
    for (int burst = 0; burst < 3; burst++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        d = 8'($urandom);
        exp_q.push_back(d);
        drive_push(d, e);
      end
      wait_drain(n * PERIOD_F + 100);
      checks++;
      if (exp_q.size() != 0 || count !== 5'd0 || empty !== 1'b1) begin
        fails++;
        $display("FAIL random_burst%0d: missing=%0d cnt=%0d empty=%b, required 0 0 1",
                 burst, exp_q.size(), count, empty);
      end
    end
  endtask

  // 18 pushes on consecutive edges from idle: the first byte is popped one edge
  // later, so the 17th push fills the FIFO and the 18th is dropped.
  task automatic test_fill_overflow();
    int e;
    logic [7:0] d;
    start_q.delete();
    fill_d0 = done_cnt;
    for (int i = 0; i < 18; i++) begin
      d = 8'($urandom);
      if (i < 17) exp_q.push_back(d);
      drive_push(d, e);
      if (i == 0) fill_e0 = e;
      if (i == 16) begin
        checks++;
        if ({full, wr_if.o_wr_ready, count, ovf} !== {1'b1, 1'b0, 5'd16, 1'b0}) begin
          fails++;
          $display("FAIL fill_full: full=%b ready=%b cnt=%0d ovf=%b, required 1 0 16 0",
                   full, wr_if.o_wr_ready, count, ovf);
        end
      end
      if (i == 17) begin
        checks++;
        if ({ovf, count, full} !== {1'b1, 5'd16, 1'b1}) begin
          fails++;
          $display("FAIL fill_overflow: ovf=%b cnt=%0d full=%b, required 1 16 1", ovf, count, full);
        end
      end
    end
  endtask

  task automatic test_overflow_clear();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++;
    if (ovf !== 1'b0 || count !== 5'd16) begin
      fails++;
      $display("FAIL ovf_clear: ovf=%b cnt=%0d, required 0 16", ovf, count);
    end
    @(negedge clk);
    clr = 1'b1;
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_data  = 8'($urandom);
    @(posedge clk);
    #1;
    clr = 1'b0;
    wr_if.i_wr_valid = 1'b0;
    checks++;
    if (ovf !== 1'b1 || count !== 5'd16) begin
      fails++;
      $display("FAIL ovf_clear_vs_set: ovf=%b cnt=%0d, required 1 16", ovf, count);
    end
  endtask

  task automatic test_full_push_pop();
    int pop_e;
    pop_e = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      wr_if.i_wr_valid = 1'b1;
      wr_if.i_wr_data  = 8'hEE;
      @(posedge clk);
      #1;
      if (count !== 5'd16) begin
        pop_e = cyc;
        break;
      end
    end
    wr_if.i_wr_valid = 1'b0;
    checks++;
    if (pop_e != fill_e0 + 1 + PERIOD_F) begin
      fails++;
      $display("FAIL full_pop_edge: count left 16 at edge %0d, required %0d", pop_e, fill_e0 + 1 + PERIOD_F);
    end
    checks++;
    if ({count, ovf, sm, wr_if.o_wr_ready} !== {5'd15, 1'b1, 3'd1, 1'b1}) begin
      fails++;
      $display("FAIL full_push_pop: cnt=%0d ovf=%b sm=%0d ready=%b, required 15 1 1 1",
               count, ovf, sm, wr_if.o_wr_ready);
    end
    wait_drain(1200);
    checks++;
    if (exp_q.size() != 0 || start_q.size() != 17 || count !== 5'd0) begin
      fails++;
      $display("FAIL full_drain: missing=%0d frames=%0d cnt=%0d, required 0 17 0",
               exp_q.size(), start_q.size(), count);
    end
    for (int k = 0; k < start_q.size(); k++) begin
      checks++;
      if (start_q[k] != fill_e0 + 2 + k * PERIOD_F) begin
        fails++;
        $display("FAIL full_start%0d: start at %0d, required %0d", k, start_q[k], fill_e0 + 2 + k * PERIOD_F);
      end
    end
    checks++;
    if (done_cnt - fill_d0 != 17) begin
      fails++;
      $display("FAIL full_done_count: %0d pulses, required 17", done_cnt - fill_d0);
    end
  endtask

  // Reset lands inside data bit 3 of 0x81 (a 0 bit) with two bytes still queued.
  task automatic test_reset_mid_frame();
    int e, e0, d0;
    drive_push(8'h81, e0);
    drive_push(8'h11, e);
    drive_push(8'h22, e);
    while (cyc < e0 + 19) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sm, txd, count} !== {3'd2, 1'b0, 5'd2}) begin
      fails++;
      $display("FAIL mid_frame_pre: sm=%0d txd=%b cnt=%0d, required 2 0 2", sm, txd, count);
    end
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({txd, tx_active, tx_done, sm, count, empty, full, wr_if.o_wr_ready, ovf} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mid_frame_reset: txd=%b act=%b done=%b sm=%0d cnt=%0d empty=%b full=%b ready=%b ovf=%b, required 1 0 0 0 0 1 0 1 0",
               txd, tx_active, tx_done, sm, count, empty, full, wr_if.o_wr_ready, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
    d0 = done_cnt;
    start_q.delete();
    repeat (150) @(negedge clk);
    checks++;
    if (start_q.size() != 0 || done_cnt != d0 || {txd, count, sm} !== {1'b1, 5'd0, 3'd0}) begin
      fails++;
      $display("FAIL mid_frame_after: frames=%0d done=%0d txd=%b cnt=%0d sm=%0d, required 0 0 1 0 0",
               start_q.size(), done_cnt - d0, txd, count, sm);
    end
  endtask

  initial begin
    wr_if.i_wr_valid = 1'b0;
    wr_if.i_wr_data  = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_random_bursts();
    test_fill_overflow();
    test_overflow_clear();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
